// File: rtl/nn_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready backpressure.
// Optional accumulate mode enabled by defining NN_MUL_ACC_EN.
module nn_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_last
);

    localparam int PW = din0_WIDTH + din1_WIDTH + 2;

    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
        $error("NUM_STAGE out of range 1..4");
    end
    if (dout_WIDTH < 2 || dout_WIDTH > din0_WIDTH + din1_WIDTH + 8) begin : g_bad_dout
        $error("dout_WIDTH out of range");
    end
    if (ID < 0) begin : g_bad_id
        $error("ID must be non-negative");
    end

    logic                  advance;
    logic                  v1;
    logic                  l1;
    logic                  sa_q;
    logic                  sb_q;
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;

    logic signed [din0_WIDTH:0] a_ext;
    logic signed [din1_WIDTH:0] b_ext;
    logic signed [PW-1:0]       prod;
    logic [dout_WIDTH-1:0]      p_res;

    logic                  v_out;
    logic                  l_out;
    logic [dout_WIDTH-1:0] r_out;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1   <= 1'b0;
            l1   <= 1'b0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (advance) begin
            v1   <= in_valid;
            l1   <= in_valid & in_last;
            sa_q <= din0_signed;
            sb_q <= din1_signed;
            a_q  <= din0;
            b_q  <= din1;
        end
    end

    // One extra bit lets unsigned operands ride through a signed multiply.
    assign a_ext = {sa_q & a_q[din0_WIDTH-1], a_q};
    assign b_ext = {sb_q & b_q[din1_WIDTH-1], b_q};
    assign prod  = a_ext * b_ext;
    assign p_res = dout_WIDTH'(prod);

    if (NUM_STAGE == 1) begin : g_one
        assign v_out = v1;
        assign l_out = l1;
        assign r_out = p_res;
    end else begin : g_many
        logic [NUM_STAGE-2:0]  v_q;
        logic [NUM_STAGE-2:0]  l_q;
        logic [dout_WIDTH-1:0] r_q [NUM_STAGE-1];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                v_q <= '0;
                l_q <= '0;
                for (int i = 0; i < NUM_STAGE - 1; i++) r_q[i] <= '0;
            end else if (advance) begin
                v_q[0] <= v1;
                l_q[0] <= l1;
                r_q[0] <= p_res;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    v_q[i] <= v_q[i-1];
                    l_q[i] <= l_q[i-1];
                    r_q[i] <= r_q[i-1];
                end
            end
        end

        assign v_out = v_q[NUM_STAGE-2];
        assign l_out = l_q[NUM_STAGE-2];
        assign r_out = r_q[NUM_STAGE-2];
    end

`ifdef NN_MUL_ACC_EN
    logic [dout_WIDTH-1:0] acc;

    // Non-last beats drain freely since out_valid stays low for them.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
        end else if (v_out & advance) begin
            acc <= l_out ? '0 : acc + r_out;
        end
    end

    assign out_valid = v_out & l_out;
    assign dout      = acc + r_out;
`else
    assign out_valid = v_out;
    assign dout      = r_out;
`endif

    assign out_last = l_out;

endmodule

// File: tb/tb_nn_mul_pipe.sv
// Self-checking bench for nn_mul_pipe: vector table, directed
// backpressure/reset sequences and a randomized scoreboarded stream.
module tb_nn_mul_pipe;

    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  din0;
    logic [7:0]  din1;
    logic        din0_signed;
    logic        din1_signed;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        out_last;

    nn_mul_pipe #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(8),
        .din1_WIDTH(8), .dout_WIDTH(16)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1),
        .din0_signed(din0_signed), .din1_signed(din1_signed),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sa;
        logic       sb;
        logic       last;
    } beat_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sa;
        logic        sb;
        logic [15:0] exp;
        string       name;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    beat_t beats[$];
    exp_t  exp_q[$];
    longint acc_sum = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input beat_t bt);
        longint x;
        longint y;
        x = longint'(bt.a);
        y = longint'(bt.b);
        if (bt.sa && bt.a[7]) x = x - 256;
        if (bt.sb && bt.b[7]) y = y - 256;
        return 16'(x * y);
    endfunction

    // Expected results of the accepted beat, by the group rule if accumulating.
    task automatic model_accept(input beat_t bt);
        exp_t e;
`ifdef NN_MUL_ACC_EN
        acc_sum = (acc_sum + longint'(ref_mul(bt))) % 65536;
        if (bt.last) begin
            e.d = 16'(acc_sum);
            e.l = 1'b1;
            exp_q.push_back(e);
            acc_sum = 0;
        end
`else
        e.d = ref_mul(bt);
        e.l = bt.last;
        exp_q.push_back(e);
`endif
    endtask

    task automatic drive_beat(input beat_t bt);
        din0        = bt.a;
        din1        = bt.b;
        din0_signed = bt.sa;
        din1_signed = bt.sb;
        in_last     = bt.last;
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_stream(input int rdy_mode, input bit vld_rand, output int cycles);
        int          idx = 0;
        bit          held = 0;
        logic [15:0] held_d = '0;
        exp_t        e;
        cycles = 0;
        while (!(idx == beats.size() && exp_q.size() == 0) && cycles < 3000) begin
            if (idx < beats.size() && (!vld_rand || $urandom_range(0, 9) < 7)) begin
                in_valid = 1'b1;
                drive_beat(beats[idx]);
            end else begin
                in_valid = 1'b0;
            end
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cycles % 3 == 0);
                default: out_ready = ($urandom_range(0, 9) < 6);
            endcase
            @(negedge clk);
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_dout", dout, held_d);
                held = 0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_dout", dout, e.d);
                        check("stream_last", out_last, e.l);
                    end
                end else begin
                    check("stall_in_ready", in_ready, 0);
                    held   = 1;
                    held_d = dout;
                end
            end
            if (in_valid && in_ready) begin
                model_accept(beats[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", idx, beats.size());
        check("stream_drained", exp_q.size(), 0);
        check("stream_idle", out_valid, 0);
    endtask

    task automatic one_beat(input beat_t bt, input logic [15:0] exp, input string name);
        int lat;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_beat(bt);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, NS);
        check({name, "_dout"}, dout, exp);
        check({name, "_last"}, out_last, bt.last);
        @(posedge clk);
        #1;
        check({name, "_consumed"}, out_valid, 0);
    endtask

    initial begin
        vec_t  vecs[10];
        beat_t bt;
        int    cyc;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, "uu_max"};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, "ss_min_max"};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01, "su_mixed"};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b1, 16'h0000, "zero"};
        vecs[4] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01, "ss_pos"};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "ss_minmin"};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001, "ss_neg1"};
        vecs[7] = '{8'h80, 8'hFF, 1'b0, 1'b1, 16'hFF80, "us_mixed"};
        vecs[8] = '{8'h01, 8'hFF, 1'b1, 1'b0, 16'h00FF, "su_pos"};
        vecs[9] = '{8'hFF, 8'h80, 1'b1, 1'b1, 16'h0080, "ss_negneg"};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        din0        = '0;
        din1        = '0;
        din0_signed = 1'b0;
        din1_signed = 1'b0;
        in_last     = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bt = '{vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 1'b1};
            one_beat(bt, vecs[i].exp, vecs[i].name);
        end

        beats.delete();
        for (int k = 1; k <= 8; k++) begin
            bt = '{8'(k), 8'(k), 1'b0, 1'b0, 1'b1};
            beats.push_back(bt);
        end
        run_stream(1, 0, cyc);

        beats.delete();
        for (int k = 0; k < 16; k++) begin
            bt = '{8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1};
            beats.push_back(bt);
        end
        run_stream(0, 0, cyc);
        check("throughput_cycles", cyc, 16 + NS);

        beats.delete();
        for (int k = 0; k < 300; k++) begin
            bt = '{8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0)};
            beats.push_back(bt);
        end
        beats[299].last = 1'b1;
        run_stream(2, 1, cyc);

`ifdef NN_MUL_ACC_EN
        beats.delete();
        beats.push_back('{8'd2, 8'd3, 1'b0, 1'b0, 1'b0});
        beats.push_back('{8'd4, 8'd5, 1'b0, 1'b0, 1'b0});
        beats.push_back('{8'd6, 8'd7, 1'b0, 1'b0, 1'b1});
        beats.push_back('{8'd1, 8'd1, 1'b0, 1'b0, 1'b0});
        beats.push_back('{8'd2, 8'd2, 1'b0, 1'b0, 1'b1});
        run_stream(0, 0, cyc);
`endif

        // Two beats in flight, then an asynchronous reset between edges.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bt = '{8'd5, 8'd6, 1'b0, 1'b0, 1'b1};
        drive_beat(bt);
        @(posedge clk);
        #1;
        bt = '{8'd7, 8'd8, 1'b0, 1'b0, 1'b1};
        drive_beat(bt);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        acc_sum  = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_dout", dout, 0);
        check("midrst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bt = '{8'd3, 8'd3, 1'b0, 1'b0, 1'b1};
        one_beat(bt, 16'd9, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
